// File: rtl/imem_loader.sv
// Instruction-memory writer: turns a length-prefixed, XOR-checksummed byte stream into
// little-endian 32-bit word writes, and holds the CPU in reset until a load succeeds.
module imem_loader #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR} state_t;

    state_t        state, state_nxt;
    logic [7:0]    len_lo;
    logic [AW:0]   len;
    logic [1:0]    lane;
    logic [AW-1:0] widx;
    logic [23:0]   wbuf;
    logic [7:0]    csum;

    logic        accept;
    logic        start_ok;
    logic [15:0] len_full;
    logic        len_bad;
    logic        last_word;
    logic        word_end;

    assign accept    = rx_valid && rx_ready;
    assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
    assign len_full  = {rx_data, len_lo};
    assign len_bad   = (len_full == 16'd0) || (len_full > 16'(DEPTH));
    assign last_word = ({1'b0, widx} == len - (AW+1)'(1));
    assign word_end  = accept && (lane == 2'd3);

    // All status outputs are pure decodes of the state so they flip on the same edge.
    assign rx_ready = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CHK);
    assign busy     = rx_ready;
    assign done     = (state == DONE);
    assign err      = (state == ERR);
    assign cpu_hold = (state != DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = LEN0;
            LEN0:            if (accept) state_nxt = LEN1;
            LEN1:            if (accept) state_nxt = len_bad ? ERR : DATA;
            DATA:            if (word_end && last_word) state_nxt = CHK;
            CHK:             if (accept) state_nxt = (rx_data == csum) ? DONE : ERR;
            default:         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_lo    <= '0;
            len       <= '0;
            lane      <= '0;
            widx      <= '0;
            wbuf      <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                lane <= '0;
                widx <= '0;
                csum <= '0;
            end
            case (state)
                LEN0: if (accept) len_lo <= rx_data;
                // Only meaningful when the length is in range; otherwise we go to ERR.
                LEN1: if (accept) len <= len_full[AW:0];
                DATA: if (accept) begin
                    csum <= csum ^ rx_data;
                    lane <= lane + 2'd1;
                    if (lane == 2'd3) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= widx;
                        mem_wdata <= {rx_data, wbuf};
                        if (!last_word) widx <= widx + AW'(1);
                    end else begin
                        wbuf[{lane, 3'b000} +: 8] <= rx_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: each task drives one scenario and checks against
// hand-computed words, write counts and status flags.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [6:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_low = 0;

    logic [6:0]  wa[$];
    logic [31:0] wd[$];

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(128), .AW(7)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    // Write log, sampled mid-cycle; one entry per cycle mem_we is high.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_waddr);
            wd.push_back(mem_wdata);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one byte, wait (bounded) for acceptance, then idle for 'gap' cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 16) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: rx_ready stuck at %b, required 1", rx_ready);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            if (rx_ready !== 1'b1) rdy_low++;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_normal(input int gap);
        logic [7:0] s [11];
        s = '{8'h02, 8'h00, 8'hAA, 8'h00, 8'hA0, 8'hE3, 8'h55, 8'h10, 8'hA0, 8'hE3, 8'hEF};
        for (int i = 0; i < 11; i++) send_byte(s[i], (i == 10) ? 0 : gap);
    endtask

    task automatic check_normal_result(input string tag);
        n_cmp++; if (wa.size() !== 2) begin n_bad++; $display("FAIL %s_wcount: got %0d, required 2", tag, wa.size()); end
        if (wa.size() == 2) begin
            n_cmp++; if (wa[0] !== 7'h00 || wd[0] !== 32'hE3A000AA) begin n_bad++; $display("FAIL %s_w0: got %h/%h, required 00/e3a000aa", tag, wa[0], wd[0]); end
            n_cmp++; if (wa[1] !== 7'h01 || wd[1] !== 32'hE3A01055) begin n_bad++; $display("FAIL %s_w1: got %h/%h, required 01/e3a01055", tag, wa[1], wd[1]); end
        end
        n_cmp++; if ({done, err, cpu_hold, busy, rx_ready} !== 5'b10000) begin n_bad++; $display("FAIL %s_status: done/err/hold/busy/rdy=%b, required 10000", tag, {done, err, cpu_hold, busy, rx_ready}); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        n_cmp++; if ({rx_ready, mem_we, busy, done, err, cpu_hold} !== 6'b000001) begin n_bad++; $display("FAIL reset_flags: rdy/we/busy/done/err/hold=%b, required 000001", {rx_ready, mem_we, busy, done, err, cpu_hold}); end
        n_cmp++; if (mem_waddr !== 7'h0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_bus: got %h/%h, required 0/0", mem_waddr, mem_wdata); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ready: got %b, required 0", rx_ready); end
    endtask

    task automatic test_normal();
        wa.delete(); wd.delete();
        pulse_start();
        n_cmp++; if ({busy, rx_ready, cpu_hold} !== 3'b111) begin n_bad++; $display("FAIL normal_len0: busy/rdy/hold=%b, required 111", {busy, rx_ready, cpu_hold}); end
        send_normal(0);
        check_normal_result("normal");
    endtask

    task automatic test_bad_checksum();
        logic [7:0] s [11];
        s = '{8'h02, 8'h00, 8'hAA, 8'h00, 8'hA0, 8'hE3, 8'h55, 8'h10, 8'hA0, 8'hE3, 8'hEE};
        wa.delete(); wd.delete();
        pulse_start();
        for (int i = 0; i < 11; i++) send_byte(s[i], 0);
        n_cmp++; if (wa.size() !== 2) begin n_bad++; $display("FAIL badck_wcount: got %0d, required 2", wa.size()); end
        n_cmp++; if ({done, err, cpu_hold, busy} !== 4'b0110) begin n_bad++; $display("FAIL badck_status: done/err/hold/busy=%b, required 0110", {done, err, cpu_hold, busy}); end
    endtask

    task automatic test_length_bounds();
        logic [7:0] b;
        logic [7:0] ck;
        logic [31:0] w;
        wa.delete(); wd.delete();
        pulse_start();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL len0_errclr: got %b, required 0", err); end
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        n_cmp++; if ({err, done, busy, rx_ready} !== 4'b1000 || wa.size() != 0) begin n_bad++; $display("FAIL len_zero: err/done/busy/rdy=%b writes=%0d, required 1000 writes=0", {err, done, busy, rx_ready}, wa.size()); end
        pulse_start();
        send_byte(8'h81, 0); send_byte(8'h00, 0);
        n_cmp++; if ({err, done} !== 2'b10 || wa.size() != 0) begin n_bad++; $display("FAIL len_129: err/done=%b writes=%0d, required 10 writes=0", {err, done}, wa.size()); end
        // Full-depth image, byte i = i*37+11 (mod 256).
        pulse_start();
        send_byte(8'h80, 0); send_byte(8'h00, 0);
        ck = 8'h00;
        for (int i = 0; i < 512; i++) begin
            b = 8'((i * 37 + 11) & 255);
            ck ^= b;
            send_byte(b, 0);
        end
        send_byte(ck, 0);
        n_cmp++; if ({done, err} !== 2'b10 || wa.size() !== 128) begin n_bad++; $display("FAIL len_128: done/err=%b writes=%0d, required 10 writes=128", {done, err}, wa.size()); end
        if (wa.size() == 128) begin
            w = {8'((511 * 37 + 11) & 255), 8'((510 * 37 + 11) & 255), 8'((509 * 37 + 11) & 255), 8'((508 * 37 + 11) & 255)};
            n_cmp++; if (wa[127] !== 7'h7F || wd[127] !== w) begin n_bad++; $display("FAIL len_128_last: got %h/%h, required 7f/%h", wa[127], wd[127], w); end
            w = {8'((23 * 37 + 11) & 255), 8'((22 * 37 + 11) & 255), 8'((21 * 37 + 11) & 255), 8'((20 * 37 + 11) & 255)};
            n_cmp++; if (wa[5] !== 7'h05 || wd[5] !== w) begin n_bad++; $display("FAIL len_128_w5: got %h/%h, required 05/%h", wa[5], wd[5], w); end
        end
    endtask

    task automatic test_gaps();
        wa.delete(); wd.delete();
        rdy_low = 0;
        pulse_start();
        send_normal(2);
        check_normal_result("gaps");
        n_cmp++; if (rdy_low !== 0) begin n_bad++; $display("FAIL gaps_ready: rx_ready low in %0d gap cycles, required 0", rdy_low); end
    endtask

    task automatic test_reset_midload();
        logic [7:0] s [7];
        s = '{8'h02, 8'h00, 8'hAA, 8'h00, 8'hA0, 8'hE3, 8'h55};
        wa.delete(); wd.delete();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(s[i], 0);
        reset_n = 1'b0;
        #2;
        n_cmp++; if ({rx_ready, mem_we, busy, done, err, cpu_hold} !== 6'b000001 || mem_waddr !== 7'h0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL midrst_async: rdy/we/busy/done/err/hold=%b bus=%h/%h, required 000001 0/0", {rx_ready, mem_we, busy, done, err, cpu_hold}, mem_waddr, mem_wdata); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (wa.size() !== 1) begin n_bad++; $display("FAIL midrst_writes: got %0d, required 1", wa.size()); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        wa.delete(); wd.delete();
        pulse_start();
        send_normal(0);
        check_normal_result("midrst_reload");
    endtask

    task automatic test_restart();
        logic [7:0] s [7];
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'h00, 0);
        pulse_start();
        send_byte(8'hA0, 0); send_byte(8'hE3, 0);
        send_byte(8'h55, 0);
        pulse_start();
        send_byte(8'h10, 0); send_byte(8'hA0, 0); send_byte(8'hE3, 0);
        send_byte(8'hEF, 0);
        check_normal_result("ignstart");
        wa.delete(); wd.delete();
        pulse_start();
        n_cmp++; if ({done, err, cpu_hold, busy} !== 4'b0011) begin n_bad++; $display("FAIL restart_clear: done/err/hold/busy=%b, required 0011", {done, err, cpu_hold, busy}); end
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hA0, 8'hE3, 8'h43};
        for (int i = 0; i < 7; i++) send_byte(s[i], 0);
        n_cmp++; if (wa.size() !== 1 || wa[0] !== 7'h00 || wd[0] !== 32'hE3A00000) begin n_bad++; $display("FAIL restart_word: writes=%0d first=%h/%h, required 1 00/e3a00000", wa.size(), wa.size() ? wa[0] : 7'h0, wd.size() ? wd[0] : 32'h0); end
        n_cmp++; if ({done, err, cpu_hold} !== 3'b100) begin n_bad++; $display("FAIL restart_done: done/err/hold=%b, required 100", {done, err, cpu_hold}); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_checksum();
        test_length_bounds();
        test_gaps();
        test_reset_midload();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
